// File: rtl/cpu_regfile_sync_nr1w.sv
// cpu_regfile_sync_nr1w: integer register file for the AsteRISC core.
// N registered read ports, one write port, x0 hard-wired to zero.
// After every reset a clear sequencer zeroes x1..x(NREG-1) while o_busy is high.
// Optional compile-time feature: define REGFILE_BYPASS_EN for write-first
// forwarding of a same-cycle write to a read port. Otherwise reads are read-first.
module cpu_regfile_sync_nr1w #(
    parameter int p_half_regfile = 0,
    parameter int p_xlen         = 32,
    parameter int p_nb_rd_ports  = 2
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    output logic                              o_busy,
    output logic                              o_addr_oob,
    input  logic [p_nb_rd_ports-1:0]          i_rd_en,
    input  logic [5*p_nb_rd_ports-1:0]        i_rd_addr,
    output logic [p_xlen*p_nb_rd_ports-1:0]   o_rd_data,
    input  logic                              i_wr_en,
    input  logic [4:0]                        i_wr_addr,
    input  logic [p_xlen-1:0]                 i_wr_data
);

    localparam bit           HALF     = (p_half_regfile != 0);
    localparam int           NREG     = HALF ? 16 : 32;
    localparam int           AW       = HALF ? 4 : 5;
    localparam logic [4:0]   LAST_IDX = 5'(NREG - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  clr_idx_q, clr_idx_d;

    logic [p_xlen-1:0] regs [NREG];

    logic              wr_oob;
    logic              wr_ok;
    logic              clr_we;
    logic [4:0]        rd_addr [p_nb_rd_ports];
    logic [p_nb_rd_ports-1:0] rd_oob;
    logic [p_xlen-1:0] rd_next [p_nb_rd_ports];

    // Clear sequencer next state: walk clr_idx up to the last register, then go READY.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == CLEAR) begin
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == LAST_IDX) begin
                state_d = READY;
            end
        end
    end

    // Sequencer state register; reset restarts the clear at x1.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (i_rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= 5'd1;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign o_busy = (state_q == CLEAR);

    // Write qualification: address bit 4 is only out of range in the half-size file.
    assign wr_oob = HALF && i_wr_en && i_wr_addr[4];
    assign wr_ok  = i_wr_en && (i_wr_addr != 5'd0) && !wr_oob
                    && (state_q == READY) && !i_rst;
    assign clr_we = (state_q == CLEAR) && !i_rst;

    // Storage: the sequencer zeroes one register per cycle, otherwise the write port updates it.
    always_ff @(posedge i_clk) begin
        // NOTE: the array has no reset branch; the clear sequencer initialises it, keeping it mappable to RAM.
        if (clr_we) begin
            regs[clr_idx_q[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            regs[i_wr_addr[AW-1:0]] <= i_wr_data;
        end
    end

    // Per-port read value: zero for x0, out-of-range or while clearing, else stored or forwarded data.
    always_comb begin
        rd_oob = '0;
        for (int k = 0; k < p_nb_rd_ports; k++) begin
            rd_addr[k] = i_rd_addr[5*k +: 5];
            rd_next[k] = '0;
            rd_oob[k]  = HALF && i_rd_en[k] && rd_addr[k][4];
            if ((state_q == READY) && (rd_addr[k] != 5'd0) && !(HALF && rd_addr[k][4])) begin
                rd_next[k] = regs[rd_addr[k][AW-1:0]];
`ifdef REGFILE_BYPASS_EN
                if (wr_ok && (i_wr_addr == rd_addr[k])) begin
                    rd_next[k] = i_wr_data;
                end
`endif
            end
        end
    end

    // Output registers: enabled ports load, disabled ports hold; OOB flag pulses for one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_data  <= '0;
            o_addr_oob <= 1'b0;
        end else begin
            o_addr_oob <= (|rd_oob) || wr_oob;
            for (int k = 0; k < p_nb_rd_ports; k++) begin
                if (i_rd_en[k]) begin
                    o_rd_data[k*p_xlen +: p_xlen] <= rd_next[k];
                end
            end
        end
    end

endmodule

// File: doc/cpu_regfile_sync_nr1w.md
# cpu_regfile_sync_nr1w

Parametrised integer register file for the AsteRISC core: N synchronous read ports, one write port, configurable data width and half/full register count. After every reset a hardware clear sequencer zeroes all registers while `o_busy` is high. Write-to-read forwarding is an optional compile-time feature. It sits between decode (read addresses) and writeback (write port), and the pipeline stalls on `o_busy`.

## Interface
- `p_half_regfile`, 0: 1 selects 16 registers (x0..x15) instead of 32.
- `p_xlen`, 32: data width in bits, 8..64.
- `p_nb_rd_ports`, 2: read port count, 1..4.
- `i_clk`  in  1  global clock.
- `i_rst`  in  1  global reset. Synchronous and active-high; one clock, no other clock domain.
- `o_busy`  out  1  clear sequence in progress; writes are ignored and reads return 0.
- `o_addr_oob`  out  1  registered; an enabled access in the previous cycle used address bit 4 while `p_half_regfile`=1.
- `i_rd_en`  in  p_nb_rd_ports  per-port read enable.
- `i_rd_addr`  in  5*p_nb_rd_ports  packed read addresses; port k uses bits [5k+4:5k].
- `o_rd_data`  out  p_xlen*p_nb_rd_ports  packed registered read data.
- `i_wr_en`  in  1  write enable.
- `i_wr_addr`  in  5  write address.
- `i_wr_data`  in  p_xlen  write data.

## Operation
- NREG = 16 if half, else 32. x0 reads as 0; writes to x0 are discarded.
- FSM has states CLEAR and READY. A 5-bit counter `clr_idx` drives the clear.
- While `i_rst`=1: state=CLEAR, `clr_idx`=1, all `o_rd_data`=0, `o_busy`=1, `o_addr_oob`=0.
- In CLEAR, each cycle: regs[clr_idx]<=0 and clr_idx++. When clr_idx==NREG-1, the FSM moves to READY after that write.
- In READY, the FSM stays until `i_rst`. Reset asserted mid-clear restarts the sequence at 1.
- Write in READY: if `i_wr_en` and addr≠0 and not OOB, regs[addr]<=i_wr_data at the clock edge. In CLEAR, writes are dropped silently.
- Read port k with `i_rd_en[k]`=1 loads its output register with:
  - 0 if addr==0, OOB, or state==CLEAR;
  - otherwise regs[addr].
- Read port k with `i_rd_en[k]`=0 holds its previous output.
- OOB exists only when half=1. It is addr[4]=1 on any enabled read or enabled write. `o_addr_oob` is set the next cycle and is valid for one cycle per event. OOB accesses never modify storage.
- Multiple ports may read the same address in the same cycle; all return identical data.

## Timing
- Read latency is 1 cycle: address/enable at edge n gives data visible after edge n+1.
- Write is visible to a read issued 1 cycle later in every configuration. A same-cycle read is governed by Configuration.
- Clear duration is NREG-1 cycles after the first edge with `i_rst`=0.
  - `o_busy` is registered and falls after edge NREG-1, i.e. after 31 cycles when full, 15 when half.
  - A read or write issued in the first cycle with `o_busy`=0 is serviced normally.
- No combinational input-to-output paths.

## Configuration
- `REGFILE_BYPASS_EN`:
  - Defined: when `i_wr_en` and `i_rd_en[k]` hit the same nonzero, non-OOB address in the same READY cycle, port k captures `i_wr_data` (write-first).
  - Undefined: port k captures the old stored value (read-first). Bypass logic is not synthesised.

## Test plan
- Reset held 3 cycles, then released (full) -> `o_busy`=1 for exactly 31 cycles, then 0. A read of x5 issued in the first free cycle returns 0.
- In READY, write x7=0xDEADBEEF; next cycle read x7 on port 0 and x0 on port 1 -> port 0 = 0xDEADBEEF, port 1 = 0.
- Write x3=0x11 then, in the same cycle as a write x3=0x22, read x3 -> 0x22 with `REGFILE_BYPASS_EN`, 0x11 without. The following read returns 0x22 in both cases.
- Half mode: write to addr 17, read addr 20 -> `o_addr_oob`=1 one cycle later and read=0. Then read x1 -> unchanged, and `o_addr_oob` returns to 0.
- Write x9=0xA5, then assert reset mid-clear at cycle 10 for 1 cycle -> `o_busy` stays 1 for 31 more cycles, and x9 then reads 0.
- `p_nb_rd_ports`=4, all ports read x9 while `i_rd_en`=4'b0101 -> ports 0 and 2 update, ports 1 and 3 hold their prior values.
